// File: rtl/text_console_writer.sv
// text_console_writer
//   Terminal engine: turns an input byte stream into writes to a character VRAM.
//   It tracks a logical cursor and handles CR, LF, BS and FF control codes.
//   Printable characters wrap to the next line at the last column.
//   Scrolling is done in hardware by rotating top_row and blanking the row that
//   becomes the new bottom line. VRAM contents are never moved. The display side
//   maps logical row r to physical row (r + top_row) mod ROWS.
// Ports
//   clk        system clock
//   btn_rst_n  asynchronous active-low reset
//   in_data    input byte; in_valid qualifies it; accepted when in_valid & in_ready
//   vram_we    VRAM port-A write strobe (registered)
//   vram_addr  {physical_row, col} for the write
//   vram_data  character to write
//   cursor_col logical cursor column
//   cursor_row logical cursor row (0 = top line of the screen)
//   top_row    physical row currently shown on screen line 0
//   busy       a clear or scroll sweep is in progress
module text_console_writer #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter int         COL_W          = $clog2(COLS),
  parameter int         ROW_W          = $clog2(ROWS),
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter bit         STRIP_B7       = 1'b1,
  parameter logic [7:0] BLANK          = 8'h20
) (
  input  logic                   clk,
  input  logic                   btn_rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   vram_we,
  output logic [ROW_W+COL_W-1:0] vram_addr,
  output logic [7:0]             vram_data,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [ROW_W-1:0]       top_row,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  // Modular row add. Both operands are below ROWS, so a single conditional
  // subtract is enough and ROWS need not be a power of two.
  function automatic logic [ROW_W-1:0] wrap_add(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  state_t                   state, state_nx;
  logic [COL_W-1:0]         sw_col, sw_col_nx;
  logic [ROW_W-1:0]         sw_row, sw_row_nx;
  logic [COL_W-1:0]         col_nx;
  logic [ROW_W-1:0]         row_nx, top_nx;
  logic                     we_nx;
  logic [ROW_W+COL_W-1:0]   addr_nx;
  logic [7:0]               data_nx;
  logic                     busy_nx;
  logic                     accept;
  logic                     do_nl;
  logic [7:0]               byte_p0;
  logic [ROW_W-1:0]         phys_row;

  assign accept   = in_valid & in_ready;
  assign byte_p0  = STRIP_B7 ? {1'b0, in_data[6:0]} : in_data;
  assign phys_row = wrap_add(cursor_row, top_row);

  always_comb begin
    state_nx  = state;
    sw_col_nx = sw_col;
    sw_row_nx = sw_row;
    col_nx    = cursor_col;
    row_nx    = cursor_row;
    top_nx    = top_row;
    we_nx     = 1'b0;
    addr_nx   = vram_addr;
    data_nx   = vram_data;
    do_nl     = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (byte_p0)
            8'h0D: col_nx = '0;
            8'h0A: do_nl = 1'b1;
            8'h08: begin
              // No reverse wrap: backspace at column 0 does nothing.
              if (cursor_col != '0) begin
                col_nx  = cursor_col - COL_W'(1);
                we_nx   = 1'b1;
                addr_nx = {phys_row, cursor_col - COL_W'(1)};
                data_nx = BLANK;
              end
            end
            8'h0C: begin
              col_nx    = '0;
              row_nx    = '0;
              top_nx    = '0;
              sw_col_nx = '0;
              sw_row_nx = '0;
              state_nx  = CLR_SCREEN;
            end
            default: begin
              if (byte_p0 >= 8'h20 && byte_p0 <= 8'h7E) begin
                we_nx   = 1'b1;
                addr_nx = {phys_row, cursor_col};
                data_nx = byte_p0;
                if (cursor_col != COL_LAST) begin
                  col_nx = cursor_col + COL_W'(1);
                end else begin
                  col_nx = '0;
                  do_nl  = 1'b1;
                end
              end
            end
          endcase

          // The old top physical row becomes the new bottom line, so it is
          // the row that gets blanked.
          if (do_nl) begin
            if (cursor_row != ROW_LAST) begin
              row_nx = cursor_row + ROW_W'(1);
            end else begin
              sw_row_nx = top_row;
              sw_col_nx = '0;
              top_nx    = wrap_add(top_row, ROW_W'(1));
              state_nx  = CLR_LINE;
            end
          end
        end
      end

      CLR_SCREEN: begin
        we_nx   = 1'b1;
        addr_nx = {sw_row, sw_col};
        data_nx = BLANK;
        if (sw_col == COL_LAST) begin
          sw_col_nx = '0;
          if (sw_row == ROW_LAST) begin
            sw_row_nx = '0;
            state_nx  = IDLE;
          end else begin
            sw_row_nx = sw_row + ROW_W'(1);
          end
        end else begin
          sw_col_nx = sw_col + COL_W'(1);
        end
      end

      CLR_LINE: begin
        we_nx   = 1'b1;
        addr_nx = {sw_row, sw_col};
        data_nx = BLANK;
        if (sw_col == COL_LAST) begin
          sw_col_nx = '0;
          state_nx  = IDLE;
        end else begin
          sw_col_nx = sw_col + COL_W'(1);
        end
      end

      default: state_nx = IDLE;
    endcase

    // Busy covers the cycle in which the last sweep write is on the bus, so
    // in_ready only rises in the cycle after it, and it drops in the cycle
    // after a byte that starts a sweep.
    busy_nx = (state != IDLE) || (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      if (CLEAR_ON_RESET) state <= CLR_SCREEN;
      else                state <= IDLE;
      sw_col     <= '0;
      sw_row     <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nx;
      sw_col     <= sw_col_nx;
      sw_row     <= sw_row_nx;
      cursor_col <= col_nx;
      cursor_row <= row_nx;
      top_row    <= top_nx;
      vram_we    <= we_nx;
      vram_addr  <= addr_nx;
      vram_data  <= data_nx;
      busy       <= busy_nx;
      in_ready   <= ~busy_nx;
    end
  end

endmodule
